// File: rtl/mips_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and the decode handshake.
// The fetch unit takes the master modport; memory/decode/branch logic takes the slave modport.
interface mips_fetch_unit_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   imem_en;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   if_valid;
    logic [INSTR_WIDTH-1:0] if_instr;
    logic [PC_WIDTH-1:0]    if_pc;
    logic                   id_ready;

    modport master (
        output pc,
        output imem_en,
        output if_valid,
        output if_instr,
        output if_pc,
        input  instr,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready
    );

    modport slave (
        input  pc,
        input  imem_en,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output instr,
        output redirect_valid,
        output redirect_pc,
        output id_ready
    );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch: PC owner, prefetch FIFO toward decode, redirect flush.
// Optional perf counters are enabled with `define MIPS_FETCH_PERF_CNT_EN.
module mips_fetch_unit #(
    parameter int                   PC_WIDTH    = 32,
    parameter int                   INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter int                   FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    mips_fetch_unit_if.master             fetch_bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef MIPS_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_fetch_cnt,
    output logic [31:0]                   perf_stall_cnt,
    output logic [31:0]                   perf_flush_cnt
`endif
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = INSTR_WIDTH + PC_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_STALL
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [CW-1:0]          count_q, count_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [ENTRY_W-1:0]     entry_q [FIFO_DEPTH];

    logic                   imem_en;
    logic                   if_valid;
    logic                   pop;
    logic                   push;
    logic                   redirect_acc;
    logic [PC_WIDTH-1:0]    redirect_aligned;
    logic [ENTRY_W-1:0]     head;

    // Redirects are only honoured once the boot cycle has passed.
    assign redirect_acc     = fetch_bus.redirect_valid && (state_q != S_BOOT);
    assign redirect_aligned = fetch_bus.redirect_pc & ~PC_WIDTH'(3);

    assign if_valid = (count_q != '0);
    assign pop      = if_valid && fetch_bus.id_ready;
    assign push     = imem_en && !fetch_bus.redirect_valid && ((count_q < DEPTH_C) || pop);

    always_comb begin
        imem_en = 1'b0;
        case (state_q)
            S_BOOT:  imem_en = 1'b0;
            S_FETCH: imem_en = 1'b1;
            S_STALL: imem_en = fetch_bus.id_ready;
            default: imem_en = 1'b0;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        pc_d     = pc_q;
        if (redirect_acc) begin
            // Flush wins over any same-cycle pop; decode still takes the head it saw.
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = redirect_aligned;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                pc_d     = pc_q + PC_WIDTH'(4);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_acc) begin
                    state_d = S_FETCH;
                end else if ((count_d == DEPTH_C) && !pop) begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                if (redirect_acc || (count_d < DEPTH_C)) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[wr_ptr_q] <= {fetch_bus.instr, pc_q};
        end
    end

    assign head = entry_q[rd_ptr_q];

    assign fetch_bus.pc       = pc_q;
    assign fetch_bus.imem_en  = imem_en;
    assign fetch_bus.if_valid = if_valid;
    assign fetch_bus.if_instr = if_valid ? head[ENTRY_W-1:PC_WIDTH] : '0;
    assign fetch_bus.if_pc    = if_valid ? head[PC_WIDTH-1:0] : '0;
    assign fifo_count         = count_q;

`ifdef MIPS_FETCH_PERF_CNT_EN
    logic [2:0] perf_inc;

    assign perf_inc[0] = push;
    assign perf_inc[1] = (state_q == S_STALL);
    assign perf_inc[2] = redirect_acc;

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [31:0] cnt_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (perf_inc[gi] && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = g_perf[0].cnt_q;
    assign perf_stall_cnt = g_perf[1].cnt_q;
    assign perf_flush_cnt = g_perf[2].cnt_q;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: memory returns pc ^ 32'hA5A5_A5A5, every step
// drives inputs on the falling edge and checks outputs 1 ns later.
module tb_mips_fetch_unit;

    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    logic       clk;
    logic       rst;
    logic [2:0] fifo_count;
    int         vectors;
    int         miscompares;

`ifdef MIPS_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    mips_fetch_unit_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    mips_fetch_unit #(
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32),
        .RESET_PC    (32'h0000_0000),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_bus  (bus),
        .fifo_count (fifo_count)
`ifdef MIPS_FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    // Combinational instruction memory.
    assign bus.instr = bus.pc ^ PAT;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        $display("[%0t] %s obs=%0h exp=%0h", $time, tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},       64'(bus.pc),       64'h0);
        chk({tag, "_imem_en"},  64'(bus.imem_en),  64'h0);
        chk({tag, "_if_valid"}, 64'(bus.if_valid), 64'h0);
        chk({tag, "_if_instr"}, 64'(bus.if_instr), 64'h0);
        chk({tag, "_if_pc"},    64'(bus.if_pc),    64'h0);
        chk({tag, "_count"},    64'(fifo_count),   64'h0);
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        rst                = 1'b1;
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset state, then streaming fetch with decode always ready
        step(); #1;
        chk_reset("rst0");
        rst = 1'b0; #1;
        chk("t1_boot_imem_en", 64'(bus.imem_en), 64'h0);
        step(); #1;
        chk("t1_c1_pc",       64'(bus.pc),       64'h0);
        chk("t1_c1_imem_en",  64'(bus.imem_en),  64'h1);
        chk("t1_c1_if_valid", 64'(bus.if_valid), 64'h0);
        step(); #1;
        chk("t1_c2_pc",       64'(bus.pc),       64'h4);
        chk("t1_c2_if_pc",    64'(bus.if_pc),    64'h0);
        chk("t1_c2_if_instr", 64'(bus.if_instr), 64'hA5A5_A5A5);
        chk("t1_c2_count",    64'(fifo_count),   64'h1);
        step(); #1;
        chk("t1_c3_pc",       64'(bus.pc),       64'h8);
        chk("t1_c3_if_pc",    64'(bus.if_pc),    64'h4);
        chk("t1_c3_if_instr", 64'(bus.if_instr), 64'hA5A5_A5A1);
        step(); #1;
        chk("t1_c4_pc",       64'(bus.pc),       64'hC);
        chk("t1_c4_if_pc",    64'(bus.if_pc),    64'h8);
        chk("t1_c4_if_instr", 64'(bus.if_instr), 64'hA5A5_A5AD);

        // Decode stalled from reset: FIFO fills and fetch stalls
        rst          = 1'b1;
        bus.id_ready = 1'b0;
        step();
        rst = 1'b0;
        repeat (5) step();
        #1;
        chk("t2_full_count",   64'(fifo_count),   64'h4);
        chk("t2_full_pc",      64'(bus.pc),       64'h10);
        chk("t2_full_imem_en", 64'(bus.imem_en),  64'h0);
        chk("t2_full_if_pc",   64'(bus.if_pc),    64'h0);
        step(); #1;
        chk("t2_hold_count",   64'(fifo_count),   64'h4);
        chk("t2_hold_pc",      64'(bus.pc),       64'h10);
        chk("t2_hold_if_instr", 64'(bus.if_instr), 64'hA5A5_A5A5);
        bus.id_ready = 1'b1; #1;
        chk("t2_ready_imem_en", 64'(bus.imem_en), 64'h1);
        step();
        bus.id_ready = 1'b0; #1;
        chk("t2_pp_count",   64'(fifo_count),  64'h4);
        chk("t2_pp_if_pc",   64'(bus.if_pc),   64'h4);
        chk("t2_pp_pc",      64'(bus.pc),      64'h14);
        chk("t2_pp_imem_en", 64'(bus.imem_en), 64'h0);

        // Redirect together with a pop while full
        step(); #1;
        chk("t4_pre_count", 64'(fifo_count), 64'h4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        bus.id_ready       = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        bus.id_ready       = 1'b0; #1;
        chk("t4_count",    64'(fifo_count),   64'h0);
        chk("t4_if_valid", 64'(bus.if_valid), 64'h0);
        chk("t4_pc",       64'(bus.pc),       64'h100);
        chk("t4_imem_en",  64'(bus.imem_en),  64'h1);
        step(); #1;
        chk("t4_next_count", 64'(fifo_count), 64'h1);
        chk("t4_next_if_pc", 64'(bus.if_pc),  64'h100);

        // Redirect near the top of the address space; PC wraps to zero
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        bus.id_ready       = 1'b1;
        step();
        bus.redirect_valid = 1'b0; #1;
        chk("t5_c1_pc",       64'(bus.pc),       64'hFFFF_FFF8);
        chk("t5_c1_if_valid", 64'(bus.if_valid), 64'h0);
        step(); #1;
        chk("t5_c2_pc",       64'(bus.pc),       64'hFFFF_FFFC);
        chk("t5_c2_if_pc",    64'(bus.if_pc),    64'hFFFF_FFF8);
        chk("t5_c2_if_instr", 64'(bus.if_instr), 64'h5A5A_5A5D);
        step(); #1;
        chk("t5_c3_pc",       64'(bus.pc),       64'h0);
        chk("t5_c3_if_pc",    64'(bus.if_pc),    64'hFFFF_FFFC);
        chk("t5_c3_if_instr", 64'(bus.if_instr), 64'h5A5A_5A59);
        step(); #1;
        chk("t5_c4_pc",       64'(bus.pc),       64'h4);
        chk("t5_c4_if_pc",    64'(bus.if_pc),    64'h0);
        chk("t5_c4_count",    64'(fifo_count),   64'h1);
        bus.id_ready = 1'b0;
        step(); #1;
        chk("t6_pre_count", 64'(fifo_count), 64'h2);

        // Reset mid-operation, redirect during boot must be ignored
        rst = 1'b1;
        step(); #1;
        chk_reset("t6_rst");
        rst                = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0800; #1;
        chk("t6_boot_imem_en", 64'(bus.imem_en), 64'h0);
        step();
        bus.redirect_valid = 1'b0; #1;
        chk("t6_c1_pc",       64'(bus.pc),       64'h0);
        chk("t6_c1_imem_en",  64'(bus.imem_en),  64'h1);
        chk("t6_c1_if_valid", 64'(bus.if_valid), 64'h0);
        step(); #1;
        chk("t6_c2_if_valid", 64'(bus.if_valid), 64'h1);
        chk("t6_c2_if_pc",    64'(bus.if_pc),    64'h0);
        chk("t6_c2_count",    64'(fifo_count),   64'h1);

        // Redirect to an unaligned target with three entries queued
        step();
        step(); #1;
        chk("t3_pre_count", 64'(fifo_count), 64'h3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0403;
        step();
        bus.redirect_valid = 1'b0; #1;
        chk("t3_c1_if_valid", 64'(bus.if_valid), 64'h0);
        chk("t3_c1_count",    64'(fifo_count),   64'h0);
        chk("t3_c1_pc",       64'(bus.pc),       64'h400);
        step(); #1;
        chk("t3_c2_if_valid", 64'(bus.if_valid), 64'h1);
        chk("t3_c2_if_pc",    64'(bus.if_pc),    64'h400);
        chk("t3_c2_if_instr", 64'(bus.if_instr), 64'hA5A5_A1A5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
